// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses on a big-endian 32-bit word memory, sub-word stores by read-modify-write.
// Optional alignment checking is compiled in with the LSU_ALIGN_CHECK_EN macro.
module load_store_unit (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        CpuReq,
    input  logic        CpuWrite,
    input  logic [1:0]  CpuType,
    input  logic        CpuUnsigned,
    input  logic [31:0] CpuAddr,
    input  logic [31:0] CpuWData,
    output logic [31:0] CpuRData,
    output logic        Stall,
    output logic        Done,
    output logic        AlignErr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);

    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

    state_t      state_reg;
    size_t       req_size;
    size_t       size_reg;
    logic [1:0]  off_reg;
    logic        write_reg;
    logic        unsigned_reg;
    logic [15:0] wdata_reg;
    logic [31:0] cpu_rdata_reg;
    logic        done_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic        misaligned;

    logic [7:0]  rd_lane [4];
    logic [31:0] merged_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_value;

    // Type 11 is reserved and behaves as a word access.
    always_comb begin
        case (CpuType)
            2'b01:   req_size = SZ_HALF;
            2'b10:   req_size = SZ_BYTE;
            default: req_size = SZ_WORD;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    logic align_err_reg;

    assign misaligned = ((req_size == SZ_HALF) && CpuAddr[0]) ||
                        ((req_size == SZ_WORD) && (CpuAddr[1:0] != 2'b00));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            align_err_reg <= 1'b0;
        end else begin
            align_err_reg <= (state_reg == IDLE) && CpuReq && misaligned;
        end
    end

    assign AlignErr = align_err_reg;
`else
    assign misaligned = 1'b0;
    assign AlignErr   = 1'b0;
`endif

    // Lane gi is byte offset gi; offset 0 sits in the most significant byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_new;

            assign rd_lane[gi] = MemRData[31-8*gi -: 8];
            assign lane_hit    = (size_reg == SZ_BYTE) ? (off_reg == 2'(gi))
                                                       : (off_reg[1] == 1'(gi / 2));
            if (gi % 2 == 0) begin : g_even
                assign lane_new = (size_reg == SZ_HALF) ? wdata_reg[15:8] : wdata_reg[7:0];
            end else begin : g_odd
                assign lane_new = wdata_reg[7:0];
            end
            assign merged_word[31-8*gi -: 8] = lane_hit ? lane_new : rd_lane[gi];
        end
    endgenerate

    assign sel_byte = rd_lane[off_reg];
    assign sel_half = off_reg[1] ? MemRData[15:0] : MemRData[31:16];

    always_comb begin
        load_value = MemRData;
        case (size_reg)
            SZ_BYTE: load_value = {{24{~unsigned_reg & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_value = {{16{~unsigned_reg & sel_half[15]}}, sel_half};
            default: load_value = MemRData;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg     <= IDLE;
            size_reg      <= SZ_WORD;
            off_reg       <= 2'b00;
            write_reg     <= 1'b0;
            unsigned_reg  <= 1'b0;
            wdata_reg     <= 16'h0000;
            cpu_rdata_reg <= 32'h0000_0000;
            done_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'h0000_0000;
            mem_wdata_reg <= 32'h0000_0000;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (CpuReq) begin
                        size_reg     <= req_size;
                        off_reg      <= CpuAddr[1:0];
                        write_reg    <= CpuWrite;
                        unsigned_reg <= CpuUnsigned;
                        wdata_reg    <= CpuWData[15:0];
                        if (misaligned) begin
                            state_reg <= ERR;
                            done_reg  <= 1'b1;
                        end else if (CpuWrite && (req_size == SZ_WORD)) begin
                            state_reg     <= WR;
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= 1'b1;
                            mem_addr_reg  <= {CpuAddr[31:2], 2'b00};
                            mem_wdata_reg <= CpuWData;
                        end else begin
                            state_reg    <= RD;
                            mem_req_reg  <= 1'b1;
                            mem_we_reg   <= 1'b0;
                            mem_addr_reg <= {CpuAddr[31:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    if (MemAck) begin
                        if (write_reg) begin
                            // Keep the request up and turn it into the write-back of the merged word.
                            state_reg     <= WR;
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= merged_word;
                        end else begin
                            state_reg     <= DONE;
                            mem_req_reg   <= 1'b0;
                            cpu_rdata_reg <= load_value;
                            done_reg      <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (MemAck) begin
                        state_reg   <= DONE;
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        done_reg    <= 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                ERR:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Stall    = ((state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERR)) ||
                      ((state_reg == IDLE) && CpuReq);
    assign Done     = done_reg;
    assign CpuRData = cpu_rdata_reg;
    assign MemReq   = mem_req_reg;
    assign MemWe    = mem_we_reg;
    assign MemAddr  = mem_addr_reg;
    assign MemWData = mem_wdata_reg;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port Clk, input, 1, rising-edge clock.
REQ-002 SHALL have port Rst, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port CpuReq, input, 1, pipeline memory request, sampled only in IDLE.
REQ-004 SHALL have port CpuWrite, input, 1: 1 = store, 0 = load.
REQ-005 SHALL have port CpuType, input, 2: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-006 SHALL have port CpuUnsigned, input, 1: 1 = zero-extend loads, 0 = sign-extend.
REQ-007 SHALL have ports CpuAddr and CpuWData, input, 32 each: byte address; store data, right-aligned.
REQ-008 SHALL have port CpuRData, output, 32, extended load result.
REQ-009 SHALL have ports Stall, output, 1, and Done, output, 1: pipeline hold; one-cycle completion pulse.
REQ-010 SHALL have port AlignErr, output, 1, one-cycle misalignment pulse.
REQ-011 SHALL have ports MemReq, output, 1, and MemWe, output, 1: word-memory request; write enable.
REQ-012 SHALL have ports MemAddr and MemWData, output, 32 each: word address with [1:0] = 00; write word.
REQ-013 SHALL have ports MemRData, input, 32, and MemAck, input, 1: read word; transfer acknowledge.

Function
REQ-014 SHALL use big-endian lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; half offset 0 = bits 31:16, offset 2 = bits 15:0.
REQ-015 SHALL implement FSM states IDLE, RD, WR, DONE, ERR.
REQ-016 In IDLE with CpuReq = 1, SHALL latch address, type, data, write and unsigned at the edge.
REQ-017 From IDLE, a load or sub-word store SHALL go to RD, a word store to WR, and a misaligned request to ERR when enabled (REQ-029).
REQ-018 RD SHALL drive MemReq = 1 and MemWe = 0; when MemAck = 1 it SHALL capture MemRData, then go to DONE for a load or WR for a store.
REQ-019 For sub-word stores, WR SHALL write the captured word with only the addressed lane(s) replaced by CpuWData[7:0] or [15:0] (read-modify-write); it SHALL write CpuWData unchanged for word stores.
REQ-020 WR SHALL drive MemReq = 1 and MemWe = 1, and go to DONE when MemAck = 1.
REQ-021 MemAddr, MemWe and MemWData SHALL stay stable while MemReq = 1; MemReq SHALL drop the cycle after MemAck; MemAck in the same cycle as MemReq assertion SHALL be legal (zero-wait).
REQ-022 MemAck while MemReq = 0 SHALL be ignored.
REQ-023 DONE SHALL assert Done for one cycle, then return to IDLE; CpuRData SHALL be updated on entry to DONE for loads and held until the next load completes.
REQ-024 ERR SHALL assert AlignErr and Done for one cycle, issue no MemReq, leave CpuRData unchanged, then return to IDLE.
REQ-025 Stall SHALL equal (state != IDLE && state != DONE && state != ERR) || (state == IDLE && CpuReq), combinationally.
REQ-026 CpuReq while busy SHALL be ignored, not queued.
REQ-027 Minimum latency from accept edge to Done SHALL be: load 2 cycles; word store 2 cycles; sub-word store 3 cycles; misaligned 1 cycle.

Reset
REQ-028 Rst SHALL force IDLE at the next edge and zero CpuRData, Done, AlignErr, MemReq, MemWe, MemAddr and MemWData, including mid-transfer; an abandoned MemAck SHALL be ignored.

Configuration
REQ-029 With macro LSU_ALIGN_CHECK_EN defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL go to ERR; without the macro, AlignErr SHALL be tied 0, a half access SHALL ignore addr[0], and a word access SHALL ignore addr[1:0].

Verification
REQ-030 Memory word 0x100 = 0x8899AABB; lb 0x101 -> CpuRData 0xFFFFFF99; lbu 0x101 -> 0x00000099, Done after 2 cycles with zero-wait ack.
REQ-031 lh 0x102 -> 0xFFFFAABB; lhu 0x100 -> 0x00008899.
REQ-032 sb 0x103 with data 0x12 -> one read, then a write of 0x8899AA12 to MemAddr 0x100; sh 0x100 with data 0x1234 -> write 0x1234AABB.
REQ-033 lw 0x104 with MemAck delayed 3 cycles -> MemReq held for 4 cycles with stable MemAddr 0x104; Stall high throughout; Done 1 cycle after ack.
REQ-034 With LSU_ALIGN_CHECK_EN, lw 0x102 -> AlignErr and Done for 1 cycle, no MemReq; without the macro -> reads word 0x100.
REQ-035 Rst asserted during the WR wait -> next edge IDLE with MemReq = 0 and all outputs 0; a late MemAck causes no state change.
